// File: rtl/matmul_tile_ctrl_if.sv
// Scheduler, RAM read-port and MAC-array signals of the
// tile controller, grouped so the controller sees one bundle.
interface matmul_tile_ctrl_if #(
  parameter int AW = 16,
  parameter int TW = 8
);
  logic          start;
  logic [TW-1:0] num_tiles;
  logic [AW-1:0] data_base;
  logic [AW-1:0] wt_base;
  logic          busy;

  logic          data_rd_en;
  logic [AW-1:0] data_addr;
  logic [255:0]  data_rdata;
  logic          wt_rd_en;
  logic [AW-1:0] wt_addr;
  logic [255:0]  wt_rdata;

  logic [255:0]  dp_data;
  logic [4095:0] dp_weight;
  logic [511:0]  dp_sum_in;
  logic [511:0]  dp_sum_out;

  logic [511:0]  result;
  logic          result_valid;
  logic          result_ready;

  modport master (
    output start, num_tiles, data_base, wt_base,
    output data_rdata, wt_rdata, dp_sum_out,
    output result_ready,
    input  busy, data_rd_en, data_addr,
    input  wt_rd_en, wt_addr,
    input  dp_data, dp_weight, dp_sum_in,
    input  result, result_valid
  );

  modport slave (
    input  start, num_tiles, data_base, wt_base,
    input  data_rdata, wt_rdata, dp_sum_out,
    input  result_ready,
    output busy, data_rd_en, data_addr,
    output wt_rd_en, wt_addr,
    output dp_data, dp_weight, dp_sum_in,
    output result, result_valid
  );
endinterface

// File: rtl/matmul_tile_ctrl.sv
// K-tile sequencer for the 16x16 MAC array: fetches data and
// weight rows, folds the array sum into acc, returns the result.
module matmul_tile_ctrl #(
  parameter int AW = 16,
  parameter int TW = 8
) (
  input logic              clk,
  input logic              rst,
  matmul_tile_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    MAC,
    OUT
  } state_t;

  state_t              state;
  logic [TW-1:0]       ntiles;
  logic [TW-1:0]       t;
  logic [TW-1:0]       t_nx;
  logic [AW-1:0]       dbase;
  logic [AW-1:0]       wbase;
  logic [4:0]          c;
  logic [4:0]          c_d;
  logic                cap;
  logic [255:0]        dvec;
  logic [15:0][255:0]  wrow;
  logic [511:0]        acc;
  logic                busy;
  logic                drd;
  logic                wrd;
  logic [AW-1:0]       daddr;
  logic [AW-1:0]       waddr;
  logic                rv;

  assign t_nx = t + TW'(1);

  assign bus.busy         = busy;
  assign bus.data_rd_en   = drd;
  assign bus.data_addr    = daddr;
  assign bus.wt_rd_en     = wrd;
  assign bus.wt_addr      = waddr;
  assign bus.dp_data      = dvec;
  assign bus.dp_weight    = wrow;
  assign bus.dp_sum_in    = acc;
  assign bus.result       = acc;
  assign bus.result_valid = rv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ntiles <= '0;
      t      <= '0;
      dbase  <= '0;
      wbase  <= '0;
      c      <= '0;
      c_d    <= '0;
      cap    <= 1'b0;
      dvec   <= '0;
      wrow   <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      drd    <= 1'b0;
      wrd    <= 1'b0;
      daddr  <= '0;
      waddr  <= '0;
      rv     <= 1'b0;
    end else begin
      // returns land one cycle after issue, tagged by c_d
      cap <= (state == LOAD);
      c_d <= c;
      if (cap) begin
        if (c_d == 5'd0)
          dvec <= bus.data_rdata;
        else
          wrow[c_d[3:0] - 4'd1] <= bus.wt_rdata;
      end

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            ntiles <= bus.num_tiles;
            dbase  <= bus.data_base;
            wbase  <= bus.wt_base;
            acc    <= '0;
            t      <= '0;
            c      <= '0;
            busy   <= 1'b1;
            if (bus.num_tiles == '0) begin
              state <= OUT;
              rv    <= 1'b1;
            end else begin
              state <= LOAD;
              drd   <= 1'b1;
              daddr <= bus.data_base;
            end
          end
        end

        LOAD: begin
          drd <= 1'b0;
          if (c == 5'd16) begin
            wrd   <= 1'b0;
            state <= WAIT;
          end else begin
            c     <= c + 5'd1;
            wrd   <= 1'b1;
            waddr <= wbase + (AW'(t) << 4) + AW'(c);
          end
        end

        WAIT: state <= MAC;

        MAC: begin
          acc <= bus.dp_sum_out;
          t   <= t_nx;
          c   <= '0;
          if (t_nx == ntiles) begin
            state <= OUT;
            rv    <= 1'b1;
          end else begin
            state <= LOAD;
            drd   <= 1'b1;
            daddr <= dbase + AW'(t_nx);
          end
        end

        OUT: begin
          if (bus.result_ready) begin
            rv    <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
